// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Holds the accelerator program in an on-chip instruction RAM. It issues one
// registered instruction word per cycle to the master controller.
// Hardware loops (two levels) and HALT are resolved here and replaced by NOPs,
// so the controller only ever receives datapath opcodes.
//
// Ports
//   CLK          clock
//   RSTn         synchronous active-low reset
//   progWrite    host RAM write strobe (honoured only in IDLE/DONE/ERROR)
//   progAddr     host RAM write address
//   progData     host RAM write data
//   progLength   index of the last valid instruction
//   start        one-cycle run pulse (honoured only in IDLE/DONE/ERROR)
//   pause        freeze issue while high
//   instruction  registered word to the master controller
//   busy         high from an accepted start until DONE/ERROR
//   done         sticky, program finished normally
//   error        sticky, loop stack fault
//   pc           current fetch address
module instruction_sequencer #(
  parameter int INS_WIDTH = 26,
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 progWrite,
  input  logic [PC_WIDTH-1:0]  progAddr,
  input  logic [INS_WIDTH-1:0] progData,
  input  logic [PC_WIDTH-1:0]  progLength,
  input  logic                 start,
  input  logic                 pause,
  output logic [INS_WIDTH-1:0] instruction,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [PC_WIDTH-1:0]  pc
);

  localparam logic [3:0] OP_NOP        = 4'b0111;
  localparam logic [3:0] OP_HALT       = 4'b0101;
  localparam logic [3:0] OP_LOOP_BEGIN = 4'b1101;
  localparam logic [3:0] OP_LOOP_END   = 4'b1111;
  localparam logic [INS_WIDTH-1:0] NOP_WORD = {OP_NOP, {(INS_WIDTH-4){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  // Registered state
  state_t               r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [INS_WIDTH-1:0] r_instr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic [1:0]           r_depth;
  logic [PC_WIDTH-1:0]  r_stk_start [0:1];
  logic [CNT_WIDTH-1:0] r_stk_cnt   [0:1];
  logic                 r_squash;   // discard the word now in the read register
  logic                 r_halt;     // finishing: next active cycle enters DONE
  logic [PC_WIDTH-1:0]  r_raddr;    // address of the word in r_rdata
  logic [INS_WIDTH-1:0] r_rdata;
  logic [INS_WIDTH-1:0] r_ram [0:(2**PC_WIDTH)-1];

  // Next-state values
  state_t               w_state;
  logic [PC_WIDTH-1:0]  w_pc;
  logic [INS_WIDTH-1:0] w_instr;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_error;
  logic [1:0]           w_depth;
  logic [PC_WIDTH-1:0]  w_stk_start [0:1];
  logic [CNT_WIDTH-1:0] w_stk_cnt   [0:1];
  logic                 w_squash;
  logic                 w_halt;
  logic                 w_rd_en;
  logic                 w_wr_en;

  // Decode of the word currently in the read register
  logic [3:0]           w_op;
  logic [CNT_WIDTH-1:0] w_cnt_field;
  logic                 w_top;       // index of the top stack entry (depth-1)
  logic                 w_push_idx;  // index a push writes to (depth)
  logic                 w_is_last;
  logic [CNT_WIDTH-1:0] w_cnt_dec;

  assign w_op        = r_rdata[INS_WIDTH-1 -: 4];
  assign w_cnt_field = r_rdata[CNT_WIDTH-1:0];
  assign w_top       = r_depth[1];
  assign w_push_idx  = r_depth[0];
  assign w_is_last   = (r_raddr == progLength);
  assign w_cnt_dec   = r_stk_cnt[w_top] - CNT_WIDTH'(1);
  assign w_wr_en     = RSTn & progWrite &
                       ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));

  // Next-state and output decode for the sequencer FSM
  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_instr     = NOP_WORD;
    w_busy      = r_busy;
    w_done      = r_done;
    w_error     = r_error;
    w_depth     = r_depth;
    w_stk_start = r_stk_start;
    w_stk_cnt   = r_stk_cnt;
    w_squash    = r_squash;
    w_halt      = r_halt;
    w_rd_en     = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state  = S_FETCH;
          w_pc     = {PC_WIDTH{1'b0}};
          w_busy   = 1'b1;
          w_done   = 1'b0;
          w_error  = 1'b0;
          w_depth  = 2'd0;
          w_squash = 1'b0;
          w_halt   = 1'b0;
        end else begin
          w_state = r_state;
        end
      end

      S_FETCH: begin
        // Priming read of address 0
        w_rd_en = 1'b1;
        w_pc    = r_pc + PC_WIDTH'(1);
        w_state = S_RUN;
      end

      S_RUN: begin
        if (pause) begin
          w_state = S_RUN;
        end else if (r_halt) begin
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_halt  = 1'b0;
        end else if (r_squash) begin
          // Word fetched behind a taken loop-back is dropped
          w_rd_en  = 1'b1;
          w_pc     = r_pc + PC_WIDTH'(1);
          w_squash = 1'b0;
        end else begin
          w_rd_en = 1'b1;
          w_pc    = r_pc + PC_WIDTH'(1);
          case (w_op)
            OP_HALT: begin
              w_rd_en = 1'b0;
              w_pc    = r_pc;
              w_halt  = 1'b1;
            end
            OP_LOOP_BEGIN: begin
              if (r_depth == 2'd2) begin
                w_state = S_ERROR;
                w_busy  = 1'b0;
                w_error = 1'b1;
                w_rd_en = 1'b0;
                w_pc    = r_pc;
              end else begin
                w_stk_start[w_push_idx] = r_raddr + PC_WIDTH'(1);
                w_stk_cnt[w_push_idx]   = (w_cnt_field == {CNT_WIDTH{1'b0}}) ?
                                          CNT_WIDTH'(1) : w_cnt_field;
                w_depth = r_depth + 2'd1;
                if (w_is_last) begin
                  w_rd_en = 1'b0;
                  w_pc    = r_pc;
                  w_halt  = 1'b1;
                end else begin
                  w_halt = r_halt;
                end
              end
            end
            OP_LOOP_END: begin
              if (r_depth == 2'd0) begin
                w_state = S_ERROR;
                w_busy  = 1'b0;
                w_error = 1'b1;
                w_rd_en = 1'b0;
                w_pc    = r_pc;
              end else if (w_cnt_dec != {CNT_WIDTH{1'b0}}) begin
                // Taken: jump back, the word already fetched is squashed
                w_stk_cnt[w_top] = w_cnt_dec;
                w_pc     = r_stk_start[w_top];
                w_squash = 1'b1;
              end else begin
                w_depth = r_depth - 2'd1;
                if (w_is_last) begin
                  w_rd_en = 1'b0;
                  w_pc    = r_pc;
                  w_halt  = 1'b1;
                end else begin
                  w_halt = r_halt;
                end
              end
            end
            default: begin
              w_instr = r_rdata;
              if (w_is_last) begin
                w_rd_en = 1'b0;
                w_pc    = r_pc;
                w_halt  = 1'b1;
              end else begin
                w_halt = r_halt;
              end
            end
          endcase
        end
      end

      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state        <= S_IDLE;
      r_pc           <= {PC_WIDTH{1'b0}};
      r_instr        <= NOP_WORD;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_depth        <= 2'd0;
      r_stk_start[0] <= {PC_WIDTH{1'b0}};
      r_stk_start[1] <= {PC_WIDTH{1'b0}};
      r_stk_cnt[0]   <= {CNT_WIDTH{1'b0}};
      r_stk_cnt[1]   <= {CNT_WIDTH{1'b0}};
      r_squash       <= 1'b0;
      r_halt         <= 1'b0;
      r_raddr        <= {PC_WIDTH{1'b0}};
    end else begin
      r_state        <= w_state;
      r_pc           <= w_pc;
      r_instr        <= w_instr;
      r_busy         <= w_busy;
      r_done         <= w_done;
      r_error        <= w_error;
      r_depth        <= w_depth;
      r_stk_start[0] <= w_stk_start[0];
      r_stk_start[1] <= w_stk_start[1];
      r_stk_cnt[0]   <= w_stk_cnt[0];
      r_stk_cnt[1]   <= w_stk_cnt[1];
      r_squash       <= w_squash;
      r_halt         <= w_halt;
      if (w_rd_en) begin
        r_raddr <= r_pc;
      end else begin
        r_raddr <= r_raddr;
      end
    end
  end

  // Host write port of the instruction RAM (contents survive reset)
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_ram[progAddr] <= progData;
    end
  end

  // Synchronous read port, held while issue is frozen
  always_ff @(posedge CLK) begin
    if (w_rd_en) begin
      r_rdata <= r_ram[r_pc];
    end
  end

  assign instruction = r_instr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign pc          = r_pc;

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

  localparam logic [25:0] W_NOP  = {4'h7, 22'h000000};
  localparam logic [25:0] W_CONV = {4'hA, 22'h012345};
  localparam logic [25:0] W_POOL = {4'h3, 22'h000ABC};
  localparam logic [25:0] W_LLK  = {4'h2, 22'h000007};
  localparam logic [25:0] W_HALT = {4'h5, 22'h000000};
  localparam logic [25:0] W_END  = {4'hF, 22'h000000};
  localparam logic [25:0] W_JUNK = {4'h9, 22'h3FFFFF};

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        progWrite;
  logic [7:0]  progAddr;
  logic [25:0] progData;
  logic [7:0]  progLength;
  logic        start;
  logic        pause;
  logic [25:0] instruction;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  pc;

  int          checks = 0;
  int          errors = 0;
  int          dp_cnt = 0;
  bit          mon_en = 1'b0;
  logic [25:0] exp_q[$];
  int          cyc;
  logic [7:0]  pc_snap;

  instruction_sequencer dut (
    .CLK(CLK), .RSTn(RSTn), .progWrite(progWrite), .progAddr(progAddr),
    .progData(progData), .progLength(progLength), .start(start), .pause(pause),
    .instruction(instruction), .busy(busy), .done(done), .error(error), .pc(pc)
  );

  always #5 CLK = ~CLK;

  function automatic logic [25:0] lb(input logic [15:0] cnt);
    lb = {4'hD, 6'h00, cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [25:0] d);
    progWrite = 1'b1;
    progAddr  = a;
    progData  = d;
    tick();
    progWrite = 1'b0;
  endtask

  // Start the loaded program and count cycles until done/error is seen.
  task automatic run_prog(input int pause_at, input int pause_len, input int wr_at,
                          output int cycles);
    int n;
    n      = 0;
    dp_cnt = 0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("pc_after_start", {24'd0, pc}, 32'd0);
    while (n < 300) begin
      pause     = (pause_at >= 0) && (n >= pause_at) && (n < pause_at + pause_len);
      progWrite = (n == wr_at);
      progAddr  = 8'd1;
      progData  = W_JUNK;
      tick();
      n++;
      if (done || error) break;
    end
    pause     = 1'b0;
    progWrite = 1'b0;
    if (!(done || error)) begin
      chk("run_timeout", 32'd0, 32'd1);
    end
    cycles = n;
  endtask

  // Scoreboard monitor: every datapath word must match the next expected one
  always @(negedge CLK) begin
    if (mon_en && (instruction !== W_NOP)) begin
      dp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none", instruction);
      end else begin
        chk("datapath_word", {6'd0, instruction}, {6'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    RSTn = 1'b0; progWrite = 1'b0; progAddr = 8'd0; progData = 26'd0;
    progLength = 8'd200; start = 1'b0; pause = 1'b0;
    tick();
    tick();
    chk("rst_instr", {6'd0, instruction}, {6'd0, W_NOP});
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    RSTn   = 1'b1;
    mon_en = 1'b1;
    tick();

    // Straight-line program ending on HALT
    wr(8'd0, W_CONV); wr(8'd1, W_POOL); wr(8'd2, W_HALT);
    exp_q.push_back(W_CONV); exp_q.push_back(W_POOL);
    run_prog(-1, 0, -1, cyc);
    chk("halt_cycles", cyc, 32'd5);
    chk("halt_dp", dp_cnt, 32'd2);
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_busy", {31'd0, busy}, 32'd0);
    chk("halt_instr", {6'd0, instruction}, {6'd0, W_NOP});
    chk("halt_pc", {24'd0, pc}, 32'd3);
    pc_snap = pc;
    tick(); tick(); tick();
    chk("halt_pc_frozen", {24'd0, pc}, {24'd0, pc_snap});

    // End of program via progLength (address 2 holds junk that must not issue)
    wr(8'd2, W_JUNK);
    progLength = 8'd1;
    exp_q.push_back(W_CONV); exp_q.push_back(W_POOL);
    run_prog(-1, 0, -1, cyc);
    chk("len_cycles", cyc, 32'd4);
    chk("len_dp", dp_cnt, 32'd2);
    chk("len_done", {31'd0, done}, 32'd1);
    chk("len_pc", {24'd0, pc}, 32'd2);
    progLength = 8'd200;

    // Single loop, count 3
    wr(8'd0, lb(16'd3)); wr(8'd1, W_LLK); wr(8'd2, W_CONV); wr(8'd3, W_END); wr(8'd4, W_HALT);
    for (int i = 0; i < 3; i++) begin exp_q.push_back(W_LLK); exp_q.push_back(W_CONV); end
    run_prog(-1, 0, -1, cyc);
    chk("loop_cycles", cyc, 32'd15);
    chk("loop_dp", dp_cnt, 32'd6);
    chk("loop_error", {31'd0, error}, 32'd0);

    // Same loop with pause held for 5 cycles mid-body
    for (int i = 0; i < 3; i++) begin exp_q.push_back(W_LLK); exp_q.push_back(W_CONV); end
    run_prog(4, 5, -1, cyc);
    chk("pause_cycles", cyc, 32'd20);
    chk("pause_dp", dp_cnt, 32'd6);
    chk("pause_done", {31'd0, done}, 32'd1);

    // Nested loops 2 x 2
    wr(8'd0, lb(16'd2)); wr(8'd1, lb(16'd2)); wr(8'd2, W_CONV); wr(8'd3, W_END);
    wr(8'd4, W_END); wr(8'd5, W_HALT);
    for (int i = 0; i < 4; i++) exp_q.push_back(W_CONV);
    run_prog(-1, 0, -1, cyc);
    chk("nest_cycles", cyc, 32'd19);
    chk("nest_dp", dp_cnt, 32'd4);
    chk("nest_error", {31'd0, error}, 32'd0);
    chk("nest_done", {31'd0, done}, 32'd1);

    // Third nested LOOP_BEGIN overflows the stack
    wr(8'd0, lb(16'd1)); wr(8'd1, lb(16'd1)); wr(8'd2, lb(16'd1)); wr(8'd3, W_HALT);
    run_prog(-1, 0, -1, cyc);
    chk("ovf_cycles", cyc, 32'd4);
    chk("ovf_error", {31'd0, error}, 32'd1);
    chk("ovf_busy", {31'd0, busy}, 32'd0);
    chk("ovf_done", {31'd0, done}, 32'd0);
    chk("ovf_instr", {6'd0, instruction}, {6'd0, W_NOP});

    // Host write while busy is ignored
    wr(8'd0, W_CONV); wr(8'd1, W_POOL); wr(8'd2, W_HALT);
    exp_q.push_back(W_CONV); exp_q.push_back(W_POOL);
    run_prog(-1, 0, 1, cyc);
    chk("busywr_cycles", cyc, 32'd5);
    chk("busywr_error", {31'd0, error}, 32'd0);
    exp_q.push_back(W_CONV); exp_q.push_back(W_POOL);
    run_prog(-1, 0, -1, cyc);
    chk("rerun_dp", dp_cnt, 32'd2);
    chk("rerun_cycles", cyc, 32'd5);

    // Loop count 0 behaves as 1
    wr(8'd0, lb(16'd0)); wr(8'd1, W_CONV); wr(8'd2, W_END); wr(8'd3, W_HALT);
    exp_q.push_back(W_CONV);
    run_prog(-1, 0, -1, cyc);
    chk("cnt0_cycles", cyc, 32'd6);
    chk("cnt0_dp", dp_cnt, 32'd1);

    // Empty body
    wr(8'd0, lb(16'd2)); wr(8'd1, W_END); wr(8'd2, W_HALT);
    run_prog(-1, 0, -1, cyc);
    chk("empty_cycles", cyc, 32'd7);
    chk("empty_dp", dp_cnt, 32'd0);
    chk("empty_error", {31'd0, error}, 32'd0);

    // Reset in the middle of a loop
    wr(8'd0, lb(16'd3)); wr(8'd1, W_LLK); wr(8'd2, W_CONV); wr(8'd3, W_END); wr(8'd4, W_HALT);
    exp_q.push_back(W_LLK); exp_q.push_back(W_CONV);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    chk("midrst_instr", {6'd0, instruction}, {6'd0, W_NOP});
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pc", {24'd0, pc}, 32'd0);
    chk("midrst_queue", exp_q.size(), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin exp_q.push_back(W_LLK); exp_q.push_back(W_CONV); end
    run_prog(-1, 0, -1, cyc);
    chk("fresh_cycles", cyc, 32'd15);
    chk("fresh_dp", dp_cnt, 32'd6);
    chk("fresh_error", {31'd0, error}, 32'd0);

    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
